// File: rtl/chip8_run_ctrl.sv
// rtl/chip8_run_ctrl.sv - Chip-8 run-control sequencer: reset/run/load/halt FSM with 60 Hz timer tick.
`timescale 1ns/1ps
module chip8_run_ctrl #(
  parameter int RST_CYCLES  = 16,
  parameter int TICK_DIV    = 200,
  parameter int MAX_RETRY   = 3,
  parameter int CLEAN_TICKS = 60
) (
  input  logic       clk_12k,
  input  logic       reset,
  input  logic       download,
  input  logic       user_reset,
  input  logic       error,
  input  logic       speed_sel,
  output logic       cpu_reset,
  output logic       cpu_run,
  output logic       tick_60,
  output logic [1:0] state,
  output logic [1:0] retry_cnt,
  output logic       halted
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CLEAN_TICKS > 1) ? $clog2(CLEAN_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_HALT = 2'd3
  } st_t;

  // Bit order in the synchroniser vectors: 0=download 1=user_reset 2=error 3=speed_sel
  logic [3:0] meta;
  logic [3:0] sync;
  logic [3:0] prev;

  always_ff @(posedge clk_12k) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= {speed_sel, error, user_reset, download};
      sync <= meta;
      prev <= sync;
    end
  end

  logic dl_s, ur_rise, er_rise, sp_chg;
  assign dl_s    = sync[0];
  assign ur_rise = sync[1] & ~prev[1];
  assign er_rise = sync[2] & ~prev[2];
  assign sp_chg  = sync[3] ^ prev[3];

  st_t         st, st_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [DW-1:0] tick_div, div_n;
  logic [CW-1:0] clean_cnt, clean_n;
  logic [1:0]    retry_n;
  logic          tick_n;

  always_ff @(posedge clk_12k) begin
    if (reset) begin
      st        <= ST_HOLD;
      hold_cnt  <= '0;
      tick_div  <= '0;
      clean_cnt <= '0;
      retry_cnt <= '0;
      cpu_reset <= 1'b1;
      cpu_run   <= 1'b0;
      tick_60   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      st        <= st_n;
      hold_cnt  <= hold_n;
      tick_div  <= div_n;
      clean_cnt <= clean_n;
      retry_cnt <= retry_n;
      cpu_reset <= (st_n != ST_RUN);
      cpu_run   <= (st_n == ST_RUN);
      tick_60   <= tick_n;
      halted    <= (st_n == ST_HALT);
    end
  end

  assign state = st;

  always_comb begin
    st_n    = st;
    hold_n  = hold_cnt;
    div_n   = tick_div;
    clean_n = clean_cnt;
    retry_n = retry_cnt;
    tick_n  = 1'b0;
    case (st)
      ST_HOLD: begin
        if (dl_s) begin
          st_n = ST_LOAD;
        end else if (ur_rise) begin
          hold_n = '0;
        end else if (hold_cnt == HW'(RST_CYCLES - 1)) begin
          st_n   = ST_RUN;
          hold_n = '0;
          div_n  = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (dl_s) begin
          st_n = ST_LOAD;
        end else if (ur_rise) begin
          st_n    = ST_HOLD;
          retry_n = '0;
        end else if (er_rise) begin
          if (retry_cnt < 2'(MAX_RETRY)) begin
            retry_n = retry_cnt + 1'b1;
            st_n    = ST_HOLD;
          end else begin
            st_n = ST_HALT;
          end
        end else if (sp_chg) begin
          st_n = ST_HOLD;
        end
        // Leaving RUN suppresses a tick that would land on the same edge
        if (st_n != ST_RUN) begin
          div_n   = '0;
          clean_n = '0;
          hold_n  = '0;
        end else if (tick_div == DW'(TICK_DIV - 1)) begin
          div_n  = '0;
          tick_n = 1'b1;
          if (clean_cnt == CW'(CLEAN_TICKS - 1)) begin
            clean_n = '0;
            retry_n = '0;
          end else begin
            clean_n = clean_cnt + 1'b1;
          end
        end else begin
          div_n = tick_div + 1'b1;
        end
      end
      ST_LOAD: begin
        if (!dl_s) begin
          st_n    = ST_HOLD;
          hold_n  = '0;
          retry_n = '0;
          clean_n = '0;
        end
      end
      ST_HALT: begin
        if (dl_s) begin
          st_n = ST_LOAD;
        end else if (ur_rise) begin
          st_n    = ST_HOLD;
          hold_n  = '0;
          retry_n = '0;
        end
      end
      default: st_n = ST_HOLD;
    endcase
  end

endmodule
